// File: rtl/clk_gate_pkg.sv
// rtl/clk_gate_pkg.sv - shared types and reset constants for the clock-gating enable controller
// Contents:
//   dom_state_t  per-domain state (ON / OFF / WAKE), 2 bits
//   RST_*        values every domain takes while rst is high
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_OFF  = 2'd1,
        ST_WAKE = 2'd2
    } dom_state_t;

    localparam dom_state_t RST_STATE   = ST_ON;
    localparam logic       RST_EN      = 1'b1;
    localparam logic       RST_WACK    = 1'b0;
    localparam logic       RST_STAT_ON = 1'b1;

endpackage

// File: rtl/clk_gate_dom.sv
// rtl/clk_gate_dom.sv - one gated clock domain: idle/wake FSM, WACK/STAT_ON flops, low-phase EN latch
// Ports:
//   clk       in   rising-edge clock (also the A input of the downstream AND2X2)
//   rst       in   asynchronous, active-high reset
//   busy      in   1 = domain needs its clock
//   wreq      in   wake request, 4-phase level
//   force_on  in   global override, keeps the domain ON/WAKE
//   idle_lim  in   consecutive idle samples before gating, 0 = never gate
//   en        out  gate enable, latched while clk is low
//   wack      out  wake acknowledge, registered
//   stat_on   out  registered, 1 = domain in ON state
module clk_gate_dom
    import clk_gate_pkg::*;
#(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy,
    input  logic              wreq,
    input  logic              force_on,
    input  logic [IDLE_W-1:0] idle_lim,
    output logic              en,
    output logic              wack,
    output logic              stat_on
);

    localparam int                WCNT_W    = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAKE_CYC - 1);

    dom_state_t        state;
    dom_state_t        state_nxt;
    logic [IDLE_W-1:0] cnt;
    logic [IDLE_W-1:0] cnt_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;
    logic              en_r;
    logic              en_r_nxt;
    logic              stat_nxt;
    logic              wack_nxt;

    logic              hold_on;
    logic [IDLE_W:0]   cnt_inc;
    logic              limit_hit;

    // Anything that keeps the domain awake restarts the idle run.
    assign hold_on = busy | wreq | force_on | (idle_lim == '0);

    // ">=" rather than "==" so that lowering idle_lim below the current run
    // gates on the very next idle sample instead of waiting for a wrap.
    assign cnt_inc   = {1'b0, cnt} + 1'b1;
    assign limit_hit = cnt_inc >= {1'b0, idle_lim};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
            cnt   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wcnt_nxt  = wcnt;
        case (state)
            ST_ON: begin
                if (hold_on) begin
                    cnt_nxt = '0;
                end else if (limit_hit) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc[IDLE_W-1:0];
                end
            end
            ST_OFF: begin
                // busy is meaningless here: the domain's own clock is stopped.
                if (wreq | force_on) begin
                    state_nxt = ST_WAKE;
                    wcnt_nxt  = '0;
                end
            end
            ST_WAKE: begin
                // A dropped wreq does not abort the wake; it always completes.
                if (wcnt == WCNT_LAST) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = '0;
                    wcnt_nxt  = '0;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RST_STATE;
                cnt_nxt   = '0;
                wcnt_nxt  = '0;
            end
        endcase
    end

    // en_r and stat_on follow the state being entered, so they change on the
    // same edge as the state; wack looks at the state being left.
    always_comb begin
        en_r_nxt = (state_nxt != ST_OFF);
        stat_nxt = (state_nxt == ST_ON);
        wack_nxt = (state == ST_ON) & wreq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r    <= RST_EN;
            stat_on <= RST_STAT_ON;
            wack    <= RST_WACK;
        end else begin
            en_r    <= en_r_nxt;
            stat_on <= stat_nxt;
            wack    <= wack_nxt;
        end
    end

    // Transparent only while clk is low, so the AND2X2 B input is stable for
    // the whole high phase. Reset forces it open regardless of clk.
    always_latch begin
        if (rst) begin
            en = RST_EN;
        end else if (!clk) begin
            en = en_r;
        end
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - per-domain clock-gating enable controller, N_DOM independent domains
// Ports:
//   clk       in   1        rising-edge clock
//   rst       in   1        asynchronous, active-high reset
//   busy      in   N_DOM    per-domain activity, 1 = domain needs clock
//   wreq      in   N_DOM    per-domain wake request, 4-phase level
//   idle_lim  in   IDLE_W   consecutive idle cycles before gating, 0 = never gate
//   force_on  in   1        global override, all domains on
//   en        out  N_DOM    gate enables to AND2X2 B inputs, low-phase latched
//   wack      out  N_DOM    wake acknowledges, registered
//   stat_on   out  N_DOM    registered, 1 = domain in ON state
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_DOM-1:0]  busy,
    input  logic [N_DOM-1:0]  wreq,
    input  logic [IDLE_W-1:0] idle_lim,
    input  logic              force_on,
    output logic [N_DOM-1:0]  en,
    output logic [N_DOM-1:0]  wack,
    output logic [N_DOM-1:0]  stat_on
);

    for (genvar i = 0; i < N_DOM; i++) begin : g_dom
        clk_gate_dom #(
            .IDLE_W   (IDLE_W),
            .WAKE_CYC (WAKE_CYC)
        ) u_dom (
            .clk      (clk),
            .rst      (rst),
            .busy     (busy[i]),
            .wreq     (wreq[i]),
            .force_on (force_on),
            .idle_lim (idle_lim),
            .en       (en[i]),
            .wack     (wack[i]),
            .stat_on  (stat_on[i])
        );
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

    localparam int N_DOM    = 4;
    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N_DOM-1:0]  busy = '1;
    logic [N_DOM-1:0]  wreq = '0;
    logic [IDLE_W-1:0] idle_lim = 8'd4;
    logic              force_on = 1'b0;
    logic [N_DOM-1:0]  en;
    logic [N_DOM-1:0]  wack;
    logic [N_DOM-1:0]  stat_on;

    int total = 0;
    int bad   = 0;

    clk_gate_ctrl #(
        .N_DOM    (N_DOM),
        .IDLE_W   (IDLE_W),
        .WAKE_CYC (WAKE_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .wreq     (wreq),
        .idle_lim (idle_lim),
        .force_on (force_on),
        .en       (en),
        .wack     (wack),
        .stat_on  (stat_on)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply reset away from the rising edge and release it in the low phase.
    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // One full cycle: inputs already set in the low phase, take the edge.
    task automatic edge_only();
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Each domain is "on", "off" or "waking"; an on domain keeps a running
    // count of idle samples and gates once that run reaches the limit; a
    // waking domain counts down WAKE_CYC edges before it is on again.
    typedef enum int { M_ON, M_OFF, M_WAKING } mmode_t;
    mmode_t     m_mode  [N_DOM];
    int         m_run   [N_DOM];
    int         m_left  [N_DOM];
    logic [3:0] m_stat, m_wack, m_en;

    task automatic model_reset();
        for (int i = 0; i < N_DOM; i++) begin
            m_mode[i] = M_ON;
            m_run[i]  = 0;
            m_left[i] = 0;
        end
        m_stat = 4'hF;
        m_wack = 4'h0;
        m_en   = 4'hF;
    endtask

    task automatic model_step(input logic [3:0] b, input logic [3:0] w,
                              input int lim, input logic f);
        for (int i = 0; i < N_DOM; i++) begin
            m_wack[i] = (m_mode[i] == M_ON) && w[i];
            case (m_mode[i])
                M_ON: begin
                    if (b[i] || w[i] || f || lim == 0) begin
                        m_run[i] = 0;
                    end else begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] >= lim) begin
                            m_mode[i] = M_OFF;
                            m_run[i]  = 0;
                        end
                    end
                end
                M_OFF: begin
                    if (w[i] || f) begin
                        m_mode[i] = M_WAKING;
                        m_left[i] = WAKE_CYC;
                    end
                end
                default: begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_mode[i] = M_ON;
                        m_run[i]  = 0;
                    end
                end
            endcase
            m_stat[i] = (m_mode[i] == M_ON);
            m_en[i]   = (m_mode[i] != M_OFF);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] busy;
        logic [3:0] wreq;
        logic [7:0] lim;
        logic       force_on;
        logic [3:0] stat;
        logic [3:0] wack;
        logic [3:0] en;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [3:0] b, input logic [3:0] w, input logic [7:0] l,
                                input logic f, input logic [3:0] s, input logic [3:0] a,
                                input logic [3:0] e);
        vec_t v;
        v.busy = b; v.wreq = w; v.lim = l; v.force_on = f;
        v.stat = s; v.wack = a; v.en = e;
        return v;
    endfunction

    logic [3:0] prev_en;

    initial begin
        // dom0 idles, domains 1-3 stay busy.
        tbl[0]  = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF); // idle 1
        tbl[1]  = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF); // idle 2
        tbl[2]  = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF); // idle 3
        tbl[3]  = mk(4'b1111, 4'h0, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF); // busy resets run
        tbl[4]  = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF);
        tbl[5]  = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF);
        tbl[6]  = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF); // 3 idle: still on
        tbl[7]  = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hE, 4'h0, 4'hE); // 4th idle: gated
        tbl[8]  = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hE, 4'h0, 4'hE);
        tbl[9]  = mk(4'b1110, 4'h1, 8'd4, 1'b0, 4'hE, 4'h0, 4'hF); // wake starts
        tbl[10] = mk(4'b1110, 4'h1, 8'd4, 1'b0, 4'hE, 4'h0, 4'hF);
        tbl[11] = mk(4'b1110, 4'h1, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF); // on after 2 edges
        tbl[12] = mk(4'b1110, 4'h1, 8'd4, 1'b0, 4'hF, 4'h1, 4'hF); // ack
        tbl[13] = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF); // ack falls
        tbl[14] = mk(4'b1110, 4'h0, 8'd4, 1'b0, 4'hF, 4'h0, 4'hF); // run = 2
        tbl[15] = mk(4'b1110, 4'h0, 8'd2, 1'b0, 4'hE, 4'h0, 4'hE); // lowered limit gates now

        // ---- 1. reset values ----
        busy = 4'hF; wreq = 4'h0; idle_lim = 8'd4; force_on = 1'b0;
        do_reset();
        chk("reset_en", 32'(en), 32'hF);
        chk("reset_wack", 32'(wack), 32'h0);
        chk("reset_stat", 32'(stat_on), 32'hF);

        // ---- table: idle gating, busy interruption, wake handshake, limit change ----
        prev_en = 4'hF;
        foreach (tbl[k]) begin
            busy = tbl[k].busy; wreq = tbl[k].wreq;
            idle_lim = tbl[k].lim; force_on = tbl[k].force_on;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_stat", k), 32'(stat_on), 32'(tbl[k].stat));
            chk($sformatf("vec%0d_wack", k), 32'(wack), 32'(tbl[k].wack));
            chk($sformatf("vec%0d_en_high", k), 32'(en), 32'(prev_en));
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_en_low", k), 32'(en), 32'(tbl[k].en));
            prev_en = tbl[k].en;
        end

        // ---- reset in the middle of dom1's wake, clock high ----
        do_reset();
        busy = 4'b1101; wreq = 4'h0; idle_lim = 8'd1;
        edge_only();
        chk("dom1_off_stat", 32'(stat_on), 32'hD);
        busy = 4'hF; wreq = 4'b0010;
        edge_only();
        chk("dom1_wake_en", 32'(en), 32'hF);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midwake_rst_en", 32'(en), 32'hF);
        chk("midwake_rst_wack", 32'(wack), 32'h0);
        chk("midwake_rst_stat", 32'(stat_on), 32'hF);
        @(negedge clk);
        #1 rst = 1'b0;
        wreq = 4'h0;

        // ---- 5. all off, then force_on wakes everything and blocks gating ----
        busy = 4'h0; idle_lim = 8'd1;
        edge_only();
        chk("all_off_stat", 32'(stat_on), 32'h0);
        chk("all_off_en", 32'(en), 32'h0);
        force_on = 1'b1;
        edge_only();
        chk("force_wake_en", 32'(en), 32'hF);
        chk("force_wake_stat", 32'(stat_on), 32'h0);
        edge_only();
        edge_only();
        chk("force_on_stat", 32'(stat_on), 32'hF);
        for (int c = 0; c < 20; c++) edge_only();
        chk("force_hold_en", 32'(en), 32'hF);
        chk("force_hold_stat", 32'(stat_on), 32'hF);
        force_on = 1'b0;

        // ---- 6. limit 0 never gates; limit 1 gates on the next edge ----
        idle_lim = 8'd0;
        begin
            int gated = 0;
            for (int c = 0; c < 300; c++) begin
                edge_only();
                if (en !== 4'hF) gated++;
            end
            chk("lim0_gated_cycles", 32'(gated), 32'd0);
        end
        idle_lim = 8'd1;
        edge_only();
        chk("lim1_stat", 32'(stat_on), 32'h0);
        chk("lim1_en", 32'(en), 32'h0);

        // ---- randomized run against the reference model ----
        busy = 4'hF; wreq = 4'h0; idle_lim = 8'd3; force_on = 1'b0;
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] old_en;
            for (int i = 0; i < N_DOM; i++) begin
                busy[i] = ($urandom_range(0, 2) == 0);
                wreq[i] = ($urandom_range(0, 7) == 0);
            end
            force_on = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 19) == 0) idle_lim = 8'($urandom_range(0, 5));
            old_en = m_en;
            model_step(busy, wreq, int'(idle_lim), force_on);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_stat", c), 32'(stat_on), 32'(m_stat));
            chk($sformatf("rnd%0d_wack", c), 32'(wack), 32'(m_wack));
            chk($sformatf("rnd%0d_en_high", c), 32'(en), 32'(old_en));
            @(negedge clk);
            #1;
            chk($sformatf("rnd%0d_en_low", c), 32'(en), 32'(m_en));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
